// File: rtl/spram_fifo_rd_stream.sv
// Read-side adapter for the dual-bank SPRAM FIFO: turns ren/empty/rdata (1-cycle read latency)
// into a registered valid/ready stream through a 2-entry prefetching skid buffer.
module spram_fifo_rd_stream #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  fifo_empty,
    output logic                  fifo_ren,
    input  logic [DATA_WIDTH-1:0] fifo_rdata,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [1:0]            occ
);

    logic [DATA_WIDTH-1:0] r_head;
    logic [DATA_WIDTH-1:0] r_tail;
    logic [1:0]            r_occ;
    logic                  r_inflight;
    logic                  r_valid;

    logic                  w_pop;
    logic                  w_cap;
    logic [2:0]            w_level;
    logic [1:0]            w_after_pop;
    logic [1:0]            w_occ_next;

    assign w_pop       = r_valid && m_ready;
    assign w_cap       = r_inflight && !flush;
    // Words held plus the one in flight, less the one leaving: ren only if a slot stays free.
    assign w_level     = {1'b0, r_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign fifo_ren    = !rst && !flush && !fifo_empty && (w_level < 3'd2);
    assign w_after_pop = r_occ - {1'b0, w_pop};
    assign w_occ_next  = flush ? 2'd0 : (w_after_pop + {1'b0, w_cap});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_occ      <= '0;
            r_inflight <= 1'b0;
            r_valid    <= 1'b0;
        end else begin
            r_inflight <= fifo_ren;
            r_occ      <= w_occ_next;
            r_valid    <= (w_occ_next != 2'd0);
            if (!flush) begin
                if (w_pop && (r_occ == 2'd2))
                    r_head <= r_tail;
                // Capture lands in head when the buffer drains this cycle, else behind it.
                if (w_cap) begin
                    if (w_after_pop == 2'd0)
                        r_head <= fifo_rdata;
                    else
                        r_tail <= fifo_rdata;
                end
            end
        end
    end

    assign m_valid = r_valid;
    assign m_data  = r_head;
    assign occ     = r_occ;

endmodule

// File: tb/tb_spram_fifo_rd_stream.sv
// Directed/random bench for spram_fifo_rd_stream with a behavioural registered-empty FIFO upstream.
module tb_spram_fifo_rd_stream;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       flush = 1'b0;
    logic       fifo_empty = 1'b1;
    logic       fifo_ren;
    logic [7:0] fifo_rdata = 8'h00;
    logic       m_valid;
    logic       m_ready = 1'b0;
    logic [7:0] m_data;
    logic [1:0] occ;

    int checks = 0;
    int errors = 0;

    logic [7:0] up_q[$];
    logic [7:0] rx_q[$];
    int         rx_cyc[$];
    int         cyc = 0;
    int         ren_cnt = 0;
    int         ren_err = 0;
    int         occ_err = 0;

    spram_fifo_rd_stream #(.DATA_WIDTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .fifo_empty (fifo_empty),
        .fifo_ren   (fifo_ren),
        .fifo_rdata (fifo_rdata),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .occ        (occ)
    );

    always #5 clk = ~clk;

    // Upstream FIFO: data one cycle after ren, empty flag registered.
    always @(posedge clk) begin
        if (fifo_ren)
            fifo_rdata <= up_q.pop_front();
        fifo_empty <= (up_q.size() == 0);
    end

    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            if (m_valid && m_ready && !flush) begin
                rx_q.push_back(m_data);
                rx_cyc.push_back(cyc);
            end
            if (fifo_ren)
                ren_cnt++;
            if (fifo_ren && fifo_empty)
                ren_err++;
            if (occ > 2'd2)
                occ_err++;
        end
    end

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_mon();
        rx_q.delete();
        rx_cyc.delete();
        ren_cnt = 0;
    endtask

    task automatic test_reset();
        up_q.push_back(8'h77);
        tick(3);
        checks++;
        if (m_valid !== 1'b0 || occ !== 2'd0 || m_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_state: m_valid=%b occ=%0d m_data=%h, need 0/0/00", m_valid, occ, m_data);
        end
        checks++;
        if (fifo_empty !== 1'b0 || fifo_ren !== 1'b0) begin
            errors++;
            $display("FAIL reset_ren: fifo_empty=%b fifo_ren=%b, need 0/0", fifo_empty, fifo_ren);
        end
        up_q.delete();
        tick(1);
        rst = 1'b0;
        tick(1);
    endtask

    task automatic test_single();
        clear_mon();
        m_ready = 1'b1;
        up_q.push_back(8'hA5);
        tick(1);
        checks++;
        if (fifo_ren !== 1'b1 || m_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_ren: fifo_ren=%b m_valid=%b, need 1/0", fifo_ren, m_valid);
        end
        tick(1);
        checks++;
        if (fifo_ren !== 1'b0 || m_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_wait: fifo_ren=%b m_valid=%b, need 0/0", fifo_ren, m_valid);
        end
        tick(1);
        checks++;
        if (m_valid !== 1'b1 || m_data !== 8'hA5 || occ !== 2'd1) begin
            errors++;
            $display("FAIL single_out: m_valid=%b m_data=%h occ=%0d, need 1/a5/1", m_valid, m_data, occ);
        end
        tick(1);
        checks++;
        if (m_valid !== 1'b0 || occ !== 2'd0 || ren_cnt != 1 || rx_q.size() != 1) begin
            errors++;
            $display("FAIL single_done: m_valid=%b occ=%0d ren_cnt=%0d rx=%0d, need 0/0/1/1",
                     m_valid, occ, ren_cnt, rx_q.size());
        end
    endtask

    task automatic test_stream();
        int bad;
        clear_mon();
        m_ready = 1'b1;
        for (int i = 0; i < 16; i++)
            up_q.push_back(8'(i));
        tick(25);
        bad = 0;
        if (rx_q.size() == 16) begin
            for (int i = 0; i < 16; i++)
                if (rx_q[i] !== 8'(i)) bad++;
        end
        checks++;
        if (rx_q.size() != 16 || bad != 0) begin
            errors++;
            $display("FAIL stream_data: got %0d words (%0d wrong), need 16 in order 00..0f", rx_q.size(), bad);
        end
        checks++;
        if (rx_cyc.size() != 16 || (rx_cyc[rx_cyc.size()-1] - rx_cyc[0]) != 15) begin
            errors++;
            $display("FAIL stream_bubble: %0d pops, need 16 on consecutive cycles", rx_cyc.size());
        end
        checks++;
        if (ren_cnt != 16) begin
            errors++;
            $display("FAIL stream_ren: fifo_ren cycles=%0d, need 16", ren_cnt);
        end
    endtask

    task automatic test_backpressure();
        int bad;
        clear_mon();
        m_ready = 1'b0;
        for (int i = 0; i < 8; i++)
            up_q.push_back(8'(i));
        tick(5);
        checks++;
        if (m_valid !== 1'b1 || m_data !== 8'h00) begin
            errors++;
            $display("FAIL bp_hold_mid: m_valid=%b m_data=%h, need 1/00", m_valid, m_data);
        end
        tick(5);
        checks++;
        if (ren_cnt != 2 || occ !== 2'd2 || m_data !== 8'h00) begin
            errors++;
            $display("FAIL bp_hold: ren_cnt=%0d occ=%0d m_data=%h, need 2/2/00", ren_cnt, occ, m_data);
        end
        m_ready = 1'b1;
        #1;
        checks++;
        if (fifo_ren !== 1'b1) begin
            errors++;
            $display("FAIL bp_ren_resume: fifo_ren=%b, need 1", fifo_ren);
        end
        tick(15);
        bad = 0;
        if (rx_q.size() == 8) begin
            for (int i = 0; i < 8; i++)
                if (rx_q[i] !== 8'(i)) bad++;
        end
        checks++;
        if (rx_q.size() != 8 || bad != 0 || (rx_cyc[rx_cyc.size()-1] - rx_cyc[0]) != 7) begin
            errors++;
            $display("FAIL bp_drain: got %0d words (%0d wrong), need 00..07 back to back", rx_q.size(), bad);
        end
    endtask

    task automatic test_random();
        int pushed;
        int budget;
        int bad;
        int first_bad;
        clear_mon();
        pushed = 0;
        budget = 0;
        while (rx_q.size() < 2000 && budget < 30000) begin
            if (pushed < 2000 && $urandom_range(1, 0) == 1) begin
                up_q.push_back(8'(pushed));
                pushed++;
            end
            m_ready = ($urandom_range(1, 0) == 1);
            tick(1);
            budget++;
        end
        m_ready = 1'b1;
        checks++;
        if (rx_q.size() != 2000) begin
            errors++;
            $display("FAIL random_count: delivered %0d words in %0d cycles, need 2000", rx_q.size(), budget);
        end
        bad = 0;
        first_bad = -1;
        for (int i = 0; i < rx_q.size(); i++) begin
            if (rx_q[i] !== 8'(i)) begin
                if (first_bad < 0) first_bad = i;
                bad++;
            end
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL random_order: %0d words out of order, first at index %0d, need 0", bad, first_bad);
        end
        checks++;
        if (occ_err != 0 || ren_err != 0) begin
            errors++;
            $display("FAIL random_invariants: occ>2 cycles=%0d ren-while-empty cycles=%0d, need 0/0", occ_err, ren_err);
        end
    endtask

    task automatic test_flush();
        clear_mon();
        m_ready = 1'b1;
        for (int i = 0; i < 32; i++)
            up_q.push_back(8'(8'h10 + i));
        tick(5);
        checks++;
        if (occ !== 2'd1 || fifo_ren !== 1'b1 || m_data !== 8'h12 || rx_q.size() != 2) begin
            errors++;
            $display("FAIL flush_pre: occ=%0d ren=%b m_data=%h rx=%0d, need 1/1/12/2", occ, fifo_ren, m_data, rx_q.size());
        end
        flush = 1'b1;
        #1;
        checks++;
        if (fifo_ren !== 1'b0) begin
            errors++;
            $display("FAIL flush_ren: fifo_ren=%b during flush, need 0", fifo_ren);
        end
        tick(1);
        flush = 1'b0;
        checks++;
        if (m_valid !== 1'b0 || occ !== 2'd0) begin
            errors++;
            $display("FAIL flush_clear: m_valid=%b occ=%0d, need 0/0", m_valid, occ);
        end
        tick(40);
        checks++;
        if (rx_q.size() != 30 || rx_q[2] !== 8'h14 || rx_q[29] !== 8'h2F) begin
            errors++;
            $display("FAIL flush_after: got %0d words, need 30 resuming at 14 ending at 2f", rx_q.size());
        end
    endtask

    task automatic test_async_reset();
        clear_mon();
        m_ready = 1'b0;
        for (int i = 0; i < 4; i++)
            up_q.push_back(8'(8'hA0 + i));
        tick(6);
        checks++;
        if (occ !== 2'd2 || m_data !== 8'hA0) begin
            errors++;
            $display("FAIL arst_pre: occ=%0d m_data=%h, need 2/a0", occ, m_data);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (m_valid !== 1'b0 || occ !== 2'd0 || fifo_ren !== 1'b0) begin
            errors++;
            $display("FAIL arst_async: m_valid=%b occ=%0d fifo_ren=%b, need 0/0/0", m_valid, occ, fifo_ren);
        end
        up_q.delete();
        tick(2);
        rst = 1'b0;
        clear_mon();
        m_ready = 1'b1;
        up_q.push_back(8'h5A);
        up_q.push_back(8'h5B);
        tick(8);
        checks++;
        if (rx_q.size() != 2 || rx_q[0] !== 8'h5A || rx_q[1] !== 8'h5B) begin
            errors++;
            $display("FAIL arst_resume: got %0d words, need 5a,5b", rx_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_stream();
        test_backpressure();
        test_random();
        test_flush();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/spram_fifo_rd_stream.md
Name: spram_fifo_rd_stream

Overview:
- Read-side adapter that sits directly downstream of the dual-bank single-port-RAM FIFO.
- Converts the FIFO's ren/empty/rdata interface (read data valid one cycle after ren) into a registered valid/ready stream for the consumer.
- Holds a 2-entry skid buffer. It prefetches ahead so the consumer gets one word per cycle sustained, with no combinational path from m_ready to fifo_ren.

Parameters:
- DATA_WIDTH, 8, width of FIFO words and of m_data.

Ports:
- clk  input  1  single clock shared with the upstream FIFO.
- rst  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous discard of all buffered and in-flight words.
- fifo_empty  input  1  upstream FIFO empty flag (registered upstream).
- fifo_ren  output  1  read request to the upstream FIFO.
- fifo_rdata  input  DATA_WIDTH  upstream read data, valid on the cycle after fifo_ren was high.
- m_valid  output  1  output word valid.
- m_ready  input  1  consumer accepts m_data.
- m_data  output  DATA_WIDTH  output word, head of the skid buffer.
- occ  output  2  words currently held in the skid buffer (0..2).

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset values:
  - m_valid=0, m_data=0, occ=0, in-flight flag=0, skid storage=0.
  - fifo_ren is combinationally 0 while rst=1.
- State:
  - 2-entry buffer: head and tail registers.
  - occ counter.
  - inflight flag = fifo_ren registered (with flush gating, below).
- pop = m_valid && m_ready.
- fifo_ren = !rst && !flush && !fifo_empty && (occ + inflight - pop) < 2. Arithmetic is 3-bit unsigned, evaluated before the clock edge.
- Capture: when inflight=1 and flush=0, fifo_rdata is written at the edge.
  - Into head if the buffer is empty after the pop.
  - Otherwise into tail.
- Pop: head <= tail when occ was 2. When pop and capture coincide with occ=1, head <= fifo_rdata.
- occ_next = occ + (inflight && !flush) - pop.
  - Never exceeds 2; this is guaranteed by the ren rule. The bench asserts it.
  - Never underflows.
- m_valid = (occ != 0). m_data = head, driven straight from the register.
- Latency: fifo_empty falls at cycle t → fifo_ren high at t → data captured at end of t+1 → m_valid high at t+2. Minimum latency is 2 cycles.
- Throughput: with m_ready held high and the FIFO non-empty, steady state is occ=1, inflight=1, one word per cycle. Zero bubbles after the initial 2-cycle fill.
- Back-pressure: with m_ready=0, at most 2 words are fetched in total, then fifo_ren stays 0.
  - On m_ready rising with occ=2, fifo_ren reasserts in that same cycle.
- Ordering: words leave in exactly the order read from the FIFO. No duplication, no loss (flush and reset excepted).
- flush:
  - At the edge: occ <= 0, m_valid deasserts the next cycle, inflight <= 0.
  - Any fifo_rdata returning in the cycle flush is high is dropped.
  - fifo_ren=0 during flush.
  - The word returned one cycle after flush deasserts is not affected, because no ren was issued during flush.
  - pop during flush is ignored; the consumer must not count it.
- Reset mid-operation: all state clears asynchronously and any in-flight word is discarded. The upstream FIFO is reset on the same signal, so no resync is needed.
- Upstream empty toggling: fifo_ren follows fifo_empty the same cycle. A ren is never issued while fifo_empty=1.

Test Plan:
- Reset, then write 1 word (0xA5) upstream; m_ready=1 → fifo_ren pulses once, m_valid high exactly 2 cycles after empty falls, m_data=0xA5, occ returns to 0.
- Preload 16 words 0x00..0x0F; m_ready=1 continuously → 16 consecutive m_valid cycles with no bubble, data 0x00..0x0F in order; fifo_ren high for exactly 16 cycles.
- Preload 8 words; m_ready=0 for 10 cycles → exactly 2 fifo_ren pulses, occ=2, m_data=0x00 held stable. Then m_ready=1 → 0x00..0x07 in order, no bubble.
- Random m_ready (50%) and random upstream writes over 2000 words → scoreboard shows in-order, lossless delivery; occ ≤ 2 and no ren while fifo_empty=1, every cycle.
- Steady stream, assert flush for 1 cycle with occ=1 and inflight=1 → next cycle m_valid=0, occ=0. The in-flight word is dropped; the next delivered word is the FIFO's following entry.
- Assert rst asynchronously mid-stream with occ=2 → m_valid, occ and fifo_ren go to 0 immediately without waiting for a clock edge. After release, the block accepts new FIFO data normally.
